// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: CSR address of the receive data register, its field positions,
// and the CSR access types shared with the decoder.
package uart_rx_pkg;

   typedef logic [11:0] CsrAddrT;
   typedef logic [31:0] word;

   typedef enum logic [1:0] {
      CSR_RW   = 2'd0,
      CSR_RS   = 2'd1,
      CSR_RC   = 2'd2,
      CSR_NONE = 2'd3
   } csr_op_t;

   localparam CsrAddrT RxDataAddr = 12'h7C1;

   localparam int unsigned RxValidBit     = 31;
   localparam int unsigned RxOverrunBit   = 30;
   localparam int unsigned RxFrameErrBit  = 29;
   localparam int unsigned RxParityErrBit = 28;

endpackage

// File: rtl/uart_rx_fifo.sv
// rx_fifo: synchronous FIFO with wrap-bit pointers; a pop frees a slot for a
// same-cycle push, so a push while full succeeds only together with a pop.
module rx_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [Width-1:0] data_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(Depth);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
   logic [Width-1:0] mem_q [Depth];
   logic             wr_en_s, rd_en_s;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign rd_en_s = pop_i && !empty_o;
   assign wr_en_s = push_i && (!full_o || rd_en_s);
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      if (wr_en_s) wr_d = wr_q + PtrOne;
      else         wr_d = wr_q;
      if (rd_en_s) rd_d = rd_q + PtrOne;
      else         rd_d = rd_q;
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wr_q <= {(AW+1){1'b0}};
         rd_q <= {(AW+1){1'b0}};
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= {Width{1'b0}};
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (wr_en_s) mem_q[wr_q[AW-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: synchronised 8N1 receiver feeding rx_fifo, popped by a read of CSR Addr.
// Defining UART_RX_PARITY_EN adds an even-parity bit after bit 7 (error flag in bit 28).
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned Oversample = 16,
   parameter int unsigned FifoDepth  = 4,
   parameter CsrAddrT     Addr       = RxDataAddr
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        rx,
   input  logic [15:0] prescaler,
   input  logic        csr_enable,
   input  logic [11:0] csr_addr,
   input  logic [4:0]  rs1_zimm,
   input  logic [31:0] rs1_data,
   input  logic [1:0]  csr_op,
   output logic [31:0] csr_data_out,
   output logic        rx_interrupt,
   output logic        have_data
);
   localparam int unsigned SW = $clog2(Oversample);
   localparam logic [SW-1:0] SmpZero = {SW{1'b0}};
   localparam logic [SW-1:0] SmpOne  = {{(SW-1){1'b0}}, 1'b1};
   localparam logic [SW-1:0] HalfM1  = SW'(Oversample / 2 - 1);
   localparam logic [SW-1:0] FullM1  = SW'(Oversample - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] AFTER_DATA = PARITY;
`else
   localparam logic [2:0] AFTER_DATA = STOP;
`endif

   logic [1:0]    sync_q, sync_d;
   logic [2:0]    state_q, state_d;
   logic [15:0]   presc_q, presc_d;
   logic [SW-1:0] smp_q, smp_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          ovr_q, ovr_d, fe_q, fe_d, irq_q, irq_d;
   logic          rx_s, tick_s, push_s, fe_set_s, rd_s, pop_s, wr_ok_s;
   logic          full_s, empty_s;
   logic [7:0]    head_s;
   logic          unused_s;
`ifdef UART_RX_PARITY_EN
   logic          pe_q, pe_d, par_ok_q, par_ok_d, pe_set_s;
`endif

   assign unused_s = ^{rs1_zimm, rs1_data, csr_op};

   assign sync_d  = {sync_q[0], rx};
   assign rx_s    = sync_q[1];
   assign tick_s  = (presc_q == prescaler);
   assign rd_s    = csr_enable && (csr_addr == Addr);
   assign pop_s   = rd_s && !empty_s;
   assign wr_ok_s = push_s && (!full_s || pop_s);
   assign irq_d   = wr_ok_s;
   assign ovr_d   = (ovr_q && !rd_s) || (push_s && full_s && !pop_s);
   assign fe_d    = (fe_q && !rd_s) || fe_set_s;
`ifdef UART_RX_PARITY_EN
   assign pe_d    = (pe_q && !rd_s) || pe_set_s;
`endif

   // Deframing FSM; the prescale counter restarts at the start-bit edge
   always_comb begin
      state_d  = state_q;
      smp_d    = smp_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push_s   = 1'b0;
      fe_set_s = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_d = par_ok_q;
      pe_set_s = 1'b0;
`endif
      if (tick_s) presc_d = 16'd0;
      else        presc_d = presc_q + 16'd1;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               smp_d   = SmpZero;
               presc_d = 16'd0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (tick_s && smp_q == HalfM1) begin
               smp_d = SmpZero;
               bit_d = 3'd0;
               if (!rx_s) state_d = DATA;
               else       state_d = IDLE;
            end else if (tick_s) begin
               smp_d = smp_q + SmpOne;
            end else begin
               smp_d = smp_q;
            end
         end
         DATA: begin
            if (tick_s && smp_q == FullM1) begin
               smp_d          = SmpZero;
               shift_d[bit_q] = rx_s;
               if (bit_q == 3'd7) state_d = AFTER_DATA;
               else               bit_d   = bit_q + 3'd1;
            end else if (tick_s) begin
               smp_d = smp_q + SmpOne;
            end else begin
               smp_d = smp_q;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick_s && smp_q == FullM1) begin
               smp_d    = SmpZero;
               par_ok_d = (rx_s == ^shift_q);
               pe_set_s = (rx_s != ^shift_q);
               state_d  = STOP;
            end else if (tick_s) begin
               smp_d = smp_q + SmpOne;
            end else begin
               smp_d = smp_q;
            end
         end
`endif
         STOP: begin
            if (tick_s && smp_q == FullM1) begin
               smp_d   = SmpZero;
               state_d = IDLE;
`ifdef UART_RX_PARITY_EN
               if (rx_s) push_s   = par_ok_q;
               else      fe_set_s = 1'b1;
`else
               if (rx_s) push_s   = 1'b1;
               else      fe_set_s = 1'b1;
`endif
            end else if (tick_s) begin
               smp_d = smp_q + SmpOne;
            end else begin
               smp_d = smp_q;
            end
         end
         default: begin
            state_d = IDLE;
            smp_d   = SmpZero;
         end
      endcase
   end

   // State, sticky flags and interrupt pulse
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sync_q   <= 2'b11;
         state_q  <= IDLE;
         presc_q  <= 16'd0;
         smp_q    <= SmpZero;
         bit_q    <= 3'd0;
         shift_q  <= 8'h00;
         ovr_q    <= 1'b0;
         fe_q     <= 1'b0;
         irq_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pe_q     <= 1'b0;
         par_ok_q <= 1'b0;
`endif
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         presc_q  <= presc_d;
         smp_q    <= smp_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         ovr_q    <= ovr_d;
         fe_q     <= fe_d;
         irq_q    <= irq_d;
`ifdef UART_RX_PARITY_EN
         pe_q     <= pe_d;
         par_ok_q <= par_ok_d;
`endif
      end
   end

   rx_fifo #(.Depth(FifoDepth), .Width(8)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .data_i  (shift_q),
      .data_o  (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign have_data    = !empty_s;
   assign rx_interrupt = irq_q;

   always_comb begin
      csr_data_out                = 32'h0000_0000;
      csr_data_out[RxValidBit]    = have_data;
      csr_data_out[RxOverrunBit]  = ovr_q;
      csr_data_out[RxFrameErrBit] = fe_q;
`ifdef UART_RX_PARITY_EN
      csr_data_out[RxParityErrBit] = pe_q;
`else
      csr_data_out[RxParityErrBit] = 1'b0;
`endif
      if (have_data) csr_data_out[7:0] = head_s;
      else           csr_data_out[7:0] = 8'h00;
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a queue-based receive model checked every
// cycle, plus literal expectations on CSR reads and interrupt counts.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int OS       = 16;
   localparam int BITCLK   = OS;
   localparam int PUSH_LAT = 3 + OS / 2 + 9 * OS;
   localparam int DEPTH    = 4;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        rx = 1'b1;
   logic [15:0] prescaler = 16'd0;
   logic        csr_enable = 1'b0;
   logic [11:0] csr_addr = 12'h000;
   logic [4:0]  rs1_zimm = 5'd0;
   logic [31:0] rs1_data = 32'd0;
   logic [1:0]  csr_op = 2'd0;
   logic [31:0] csr_data_out;
   logic        rx_interrupt;
   logic        have_data;

   uart_rx dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .rx           (rx),
      .prescaler    (prescaler),
      .csr_enable   (csr_enable),
      .csr_addr     (csr_addr),
      .rs1_zimm     (rs1_zimm),
      .rs1_data     (rs1_data),
      .csr_op       (csr_op),
      .csr_data_out (csr_data_out),
      .rx_interrupt (rx_interrupt),
      .have_data    (have_data)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int irq_cnt = 0;

   typedef struct {
      int         at;
      logic [7:0] d;
      logic       ok;
   } ev_t;

   ev_t        pend[$];
   logic [7:0] mq[$];
   logic       m_ovr = 1'b0;
   logic       m_fe  = 1'b0;
   logic       m_irq = 1'b0;
   logic       m_rd, m_pop;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a frame's byte arrives at a fixed latency after its start edge
   initial forever begin
      @(posedge clk_i or negedge reset_i);
      if (!reset_i) begin
         pend.delete();
         mq.delete();
         m_ovr = 1'b0;
         m_fe  = 1'b0;
         m_irq = 1'b0;
      end else begin
         m_rd  = csr_enable && (csr_addr == RxDataAddr);
         m_pop = m_rd && (mq.size() > 0);
         m_irq = 1'b0;
         if (m_rd) begin
            m_ovr = 1'b0;
            m_fe  = 1'b0;
         end
         if (m_pop) void'(mq.pop_front());
         if (pend.size() > 0 && pend[0].at == cyc) begin
            if (!pend[0].ok) m_fe = 1'b1;
            else if (mq.size() < DEPTH) begin
               mq.push_back(pend[0].d);
               m_irq = 1'b1;
            end else m_ovr = 1'b1;
            void'(pend.pop_front());
         end
      end
   end

   initial forever begin
      logic [31:0] exp_w;
      @(negedge clk_i);
      exp_w = {(mq.size() > 0), m_ovr, m_fe, 1'b0, 20'h00000,
               (mq.size() > 0) ? mq[0] : 8'h00};
      check("cyc_irq", {31'd0, rx_interrupt}, {31'd0, m_irq});
      check("cyc_have_data", {31'd0, have_data}, {31'd0, (mq.size() > 0)});
      check("cyc_csr", csr_data_out, exp_w);
      if (rx_interrupt) irq_cnt++;
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b);
      logic [9:0] bits;
      bits = {stop_b, d, 1'b0};
      pend.push_back('{cyc + PUSH_LAT - 1, d, stop_b});
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         repeat (BITCLK) @(posedge clk_i);
         #1;
      end
      rx = 1'b1;
   endtask

   task automatic csr_read(input string nm, input logic [31:0] exp, input logic [11:0] a);
      csr_enable = 1'b1;
      csr_addr   = a;
      csr_op     = 2'd1;
      @(negedge clk_i);
      check(nm, csr_data_out, exp);
      @(posedge clk_i);
      #1;
      csr_enable = 1'b0;
      csr_addr   = 12'h000;
   endtask

   initial begin
      int base;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_csr", csr_data_out, 32'h0000_0000);
      check("reset_have_data", {31'd0, have_data}, 32'd0);
      check("reset_irq", {31'd0, rx_interrupt}, 32'd0);
      reset_i = 1'b1;
      idle(5);

      // single byte, other-address access must not pop
      base = irq_cnt;
      send_frame(8'h55, 1'b1);
      idle(4);
      check("t1_irq_count", irq_cnt - base, 32'd1);
      csr_read("t1_other_addr", 32'h8000_0055, 12'h123);
      csr_read("t1_read", 32'h8000_0055, RxDataAddr);
      csr_read("t1_read_empty", 32'h0000_0000, RxDataAddr);

      // glitch on the line
      base = irq_cnt;
      rx = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      rx = 1'b1;
      idle(40);
      check("t2_have_data", {31'd0, have_data}, 32'd0);
      check("t2_irq_count", irq_cnt - base, 32'd0);

      // framing error
      send_frame(8'hA3, 1'b0);
      idle(40);
      check("t3_have_data", {31'd0, have_data}, 32'd0);
      csr_read("t3_read_fe", 32'h2000_0000, RxDataAddr);
      csr_read("t3_read_clr", 32'h0000_0000, RxDataAddr);

      // overrun on the fifth byte
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      idle(4);
      csr_read("t4_read1", 32'hC000_0001, RxDataAddr);
      csr_read("t4_read2", 32'h8000_0002, RxDataAddr);
      csr_read("t4_read3", 32'h8000_0003, RxDataAddr);
      csr_read("t4_read4", 32'h8000_0004, RxDataAddr);
      csr_read("t4_read5", 32'h0000_0000, RxDataAddr);

      // pop on the exact push edge while full
      base = irq_cnt;
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
      fork
         send_frame(8'h14, 1'b1);
         begin
            repeat (PUSH_LAT - 1) @(posedge clk_i);
            #1;
            csr_read("t5_read_at_push", 32'h8000_0010, RxDataAddr);
         end
      join
      idle(4);
      check("t5_irq_count", irq_cnt - base, 32'd5);
      csr_read("t5_read_11", 32'h8000_0011, RxDataAddr);
      csr_read("t5_read_12", 32'h8000_0012, RxDataAddr);
      csr_read("t5_read_13", 32'h8000_0013, RxDataAddr);
      csr_read("t5_read_14", 32'h8000_0014, RxDataAddr);
      csr_read("t5_read_empty", 32'h0000_0000, RxDataAddr);

      // reset during a frame
      send_frame(8'h5A, 1'b1);
      idle(4);
      check("t6_pre_have_data", {31'd0, have_data}, 32'd1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (60) @(posedge clk_i);
            #1;
            reset_i = 1'b0;
            #1;
            check("t6_rst_csr", csr_data_out, 32'h0000_0000);
            check("t6_rst_have_data", {31'd0, have_data}, 32'd0);
            check("t6_rst_irq", {31'd0, rx_interrupt}, 32'd0);
            repeat (3) @(posedge clk_i);
            #1;
            reset_i = 1'b1;
         end
      join
      idle(20);
      check("t6_post_have_data", {31'd0, have_data}, 32'd0);
      send_frame(8'h3C, 1'b1);
      idle(4);
      csr_read("t6_read", 32'h8000_003C, RxDataAddr);
      csr_read("t6_read_empty", 32'h0000_0000, RxDataAddr);

      idle(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
